mutex_value_rr: RTL and testbench
=================================

MUTEX_VALUE_RR -- requirements
Module: mutex_value_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of the shared value.
REQ-002 SHALL have parameter WR_NUM, default 4: number of writer ports, legal range 1..16.
REQ-003 SHALL have parameter RD_NUM, default 2: number of reader ports, legal range 1..16.
REQ-004 SHALL have parameter INIT_VALUE, default 0: value loaded at reset.
REQ-005 SHALL have parameter CHG_ONLY, default 1: 1 = notify readers only when the stored value actually changes; 0 = notify on every accepted write.
REQ-006 SHALL have port core_clk, input, 1 bit: single clock; all state on its rising edge.
REQ-007 SHALL have port core_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port wr_value_i, input, WIDTH*WR_NUM: write operand per writer; writer k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port wr_add_i, input, WR_NUM: per-writer op; 0 = SET, 1 = ADD.
REQ-010 SHALL have port wr_valid_i, input, WR_NUM: write request per writer.
REQ-011 SHALL have port wr_ready_o, output, WR_NUM: one-hot grant.
REQ-012 SHALL have port rd_valid_o, output, RD_NUM: per-reader change-pending flag.
REQ-013 SHALL have port rd_ready_i, input, RD_NUM: per-reader acknowledge.
REQ-014 SHALL have port rd_value_o, output, RD_NUM*WIDTH: value presented to each reader.
REQ-015 SHALL have port cur_value_o, output, WIDTH: stored value, direct register output.

Function
REQ-016 Arbitration: wr_ready_o SHALL be a combinational round-robin grant over wr_valid_i; at most one bit is high per cycle, and all bits are 0 when no valid is high.
REQ-017 Priority pointer: search starts at pointer P; after a grant to k, P becomes (k+1) mod WR_NUM; with no grant, P is unchanged.
REQ-018 Acceptance: a write is accepted when wr_valid_i[k] and wr_ready_o[k] are both high; a writer SHALL hold valid, operand and op stable until accepted.
REQ-019 SET: the next value SHALL equal the operand.
REQ-020 ADD: the next value SHALL equal (current + operand) mod 2^WIDTH, with overflow silently wrapping.
REQ-021 Latency: a write accepted in cycle N SHALL appear on cur_value_o and rd_value_o in cycle N+1; back-to-back accepts every cycle SHALL be supported.
REQ-022 Notification: an accepted write in cycle N sets every rd_valid_o bit in cycle N+1; exception: when CHG_ONLY=1 and next value equals current value, no bit is set.
REQ-023 Read handshake: rd_valid_o[j] SHALL stay high until rd_valid_o[j] and rd_ready_i[j] are both high in a cycle; it then clears the following cycle.
REQ-024 rd_ready_i[j] while rd_valid_o[j] is low SHALL have no effect.
REQ-025 Simultaneous set and clear: if a reader handshake coincides with a notifying write, the set SHALL win and rd_valid_o[j] stays high.
REQ-026 Coalescing: multiple updates before a reader acks SHALL raise one pending flag; rd_value_o always shows the latest value, and intermediate values are not queued.
REQ-027 Readers SHALL be independent; one reader stalling SHALL never block writers or other readers.

Reset
REQ-028 On core_rst_n low, asynchronously: value register = INIT_VALUE; rd_valid_o = 0; P = 0.
REQ-029 wr_ready_o SHALL be forced to 0 while reset is asserted.
REQ-030 A write presented in the cycle reset asserts SHALL be discarded; reset mid-pending SHALL drop all notifications.
REQ-031 Deassertion SHALL be synchronised externally; the first accept is possible on the first edge after release.

Structure
REQ-032 A shared package/include SHALL hold the op encodings OP_SET=0 and OP_ADD=1, and the parameter range limits.
REQ-033 Round-robin grant and pointer logic SHALL be a separate sub-module rr_arbiter (parameter N, inputs req/ack, output one-hot gnt), reusable elsewhere in the codebase.
REQ-034 Operand mux, adder, compare and per-reader flag array SHALL live in mutex_value_rr.

Verification (WIDTH=8, WR_NUM=4, RD_NUM=2, INIT_VALUE=8'h10, CHG_ONLY=1 unless stated)
REQ-035 Reset release, no stimulus -> cur_value_o = 8'h10, rd_valid_o = 2'b00, wr_ready_o = 4'b0000.
REQ-036 All four writers SET 8'hA0..A3, held continuously -> grants go to writers 0,1,2,3,0… in consecutive cycles; cur_value_o follows one cycle behind each grant.
REQ-037 Writer 2 ADD 8'hF5 onto 8'h10 -> cur_value_o = 8'h05 next cycle (wrap); both rd_valid_o go high.
REQ-038 SET 8'h10 onto 8'h10 -> no rd_valid_o; with CHG_ONLY=0 the same write -> rd_valid_o = 2'b11.
REQ-039 Reader 0 holds ready low while three writes land; reader 1 acks each -> reader 0 sees one flag and the final value; reader 1 sees three handshakes; a write coinciding with reader 1's ack keeps its flag high.
REQ-040 Assert core_rst_n mid-burst with both flags pending -> immediate INIT_VALUE, flags 0, next grant goes to writer 0.

Source files
------------

// File: rtl/mutex_value_rr_pkg.sv
// Shared definitions for the round-robin guarded value register:
// op encodings and legal port-count ranges.
package mutex_value_rr_pkg;

    localparam logic OP_SET = 1'b0;
    localparam logic OP_ADD = 1'b1;

    localparam int unsigned WR_NUM_MIN = 1;
    localparam int unsigned WR_NUM_MAX = 16;
    localparam int unsigned RD_NUM_MIN = 1;
    localparam int unsigned RD_NUM_MAX = 16;

endpackage

// File: rtl/mutex_value_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant over req, priority pointer
// advances past the granted requester when ack is high.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [N-1:0] gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [N-1:0]  gnt_c;
    logic          found;

    // Two passes emulate a rotated priority encoder: first at/above the pointer, then wrap.
    always_comb begin
        gnt_c = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i] && (PW'(i) >= ptr_q)) begin
                found    = 1'b1;
                gnt_c[i] = 1'b1;
                ptr_d    = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                gnt_c[i] = 1'b1;
                ptr_d    = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
        if (!ack) begin
            ptr_d = ptr_q;
        end
    end

    // No grant may escape while reset is held.
    assign gnt = rst_n ? gnt_c : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mutex_value_rr.sv
// Shared value register with round-robin arbitrated SET/ADD writers and
// per-reader coalescing change notification.
module mutex_value_rr
    import mutex_value_rr_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      WR_NUM     = 4,
    parameter int unsigned      RD_NUM     = 2,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0,
    parameter bit               CHG_ONLY   = 1'b1
) (
    input  logic                    core_clk,
    input  logic                    core_rst_n,
    input  logic [WIDTH*WR_NUM-1:0] wr_value_i,
    input  logic [WR_NUM-1:0]       wr_add_i,
    input  logic [WR_NUM-1:0]       wr_valid_i,
    output logic [WR_NUM-1:0]       wr_ready_o,
    output logic [RD_NUM-1:0]       rd_valid_o,
    input  logic [RD_NUM-1:0]       rd_ready_i,
    output logic [RD_NUM*WIDTH-1:0] rd_value_o,
    output logic [WIDTH-1:0]        cur_value_o
);

    if (WR_NUM < WR_NUM_MIN || WR_NUM > WR_NUM_MAX ||
        RD_NUM < RD_NUM_MIN || RD_NUM > RD_NUM_MAX) begin : g_param_check
        $error("mutex_value_rr: WR_NUM/RD_NUM out of range");
    end

    logic [WR_NUM-1:0] gnt;
    logic              accept;
    logic              op;
    logic              notify;
    logic [WIDTH-1:0]  operand;
    logic [WIDTH-1:0]  next_value;
    logic [WIDTH-1:0]  value_q;
    logic [WIDTH-1:0]  value_d;
    logic [RD_NUM-1:0] rd_valid_q;
    logic [RD_NUM-1:0] rd_valid_d;

    rr_arbiter #(
        .N(WR_NUM)
    ) u_arb (
        .clk  (core_clk),
        .rst_n(core_rst_n),
        .req  (wr_valid_i),
        .ack  (accept),
        .gnt  (gnt)
    );

    assign accept = |(gnt & wr_valid_i);

    // Grant is one-hot, so the last match is the only match.
    always_comb begin
        operand = '0;
        op      = OP_SET;
        for (int unsigned k = 0; k < WR_NUM; k++) begin
            if (gnt[k]) begin
                operand = wr_value_i[k*WIDTH +: WIDTH];
                op      = wr_add_i[k];
            end
        end
    end

    // Set beats a coinciding reader ack, so notify overrides the clear.
    always_comb begin
        next_value = (op == OP_ADD) ? value_q + operand : operand;
        notify     = accept && (!CHG_ONLY || (next_value != value_q));
        value_d    = accept ? next_value : value_q;
        rd_valid_d = notify ? '1 : (rd_valid_q & ~rd_ready_i);
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            value_q    <= INIT_VALUE;
            rd_valid_q <= '0;
        end else begin
            value_q    <= value_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign wr_ready_o  = gnt;
    assign rd_valid_o  = rd_valid_q;
    assign rd_value_o  = {RD_NUM{value_q}};
    assign cur_value_o = value_q;

endmodule

// File: tb/tb_mutex_value_rr.sv
// Directed bench for mutex_value_rr (WIDTH=8, 4 writers, 2 readers); a second
// instance with CHG_ONLY=0 shares the stimulus.
module tb_mutex_value_rr;

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_value;
    logic [3:0]  wr_add;
    logic [3:0]  wr_valid;
    logic [1:0]  rd_ready;
    logic [3:0]  wr_ready;
    logic [3:0]  wr_ready_nc;
    logic [1:0]  rd_valid;
    logic [1:0]  rd_valid_nc;
    logic [15:0] rd_value;
    logic [15:0] rd_value_nc;
    logic [7:0]  cur;
    logic [7:0]  cur_nc;

    int checks = 0;
    int errors = 0;
    int hs1    = 0;

    mutex_value_rr #(
        .WIDTH(8), .WR_NUM(4), .RD_NUM(2), .INIT_VALUE(8'h10), .CHG_ONLY(1'b1)
    ) dut (
        .core_clk(clk), .core_rst_n(rst_n),
        .wr_value_i(wr_value), .wr_add_i(wr_add), .wr_valid_i(wr_valid),
        .wr_ready_o(wr_ready), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .rd_value_o(rd_value), .cur_value_o(cur)
    );

    mutex_value_rr #(
        .WIDTH(8), .WR_NUM(4), .RD_NUM(2), .INIT_VALUE(8'h10), .CHG_ONLY(1'b0)
    ) dut_nc (
        .core_clk(clk), .core_rst_n(rst_n),
        .wr_value_i(wr_value), .wr_add_i(wr_add), .wr_valid_i(wr_valid),
        .wr_ready_o(wr_ready_nc), .rd_valid_o(rd_valid_nc), .rd_ready_i(rd_ready),
        .rd_value_o(rd_value_nc), .cur_value_o(cur_nc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        if (rd_valid[1] && rd_ready[1]) hs1++;
        @(posedge clk);
        #1;
    endtask

    task automatic ack_all();
        rd_ready = 2'b11;
        tick();
        rd_ready = 2'b00;
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_value = '0;
        wr_add   = '0;
        wr_valid = 4'b1111;
        rd_ready = '0;
        #1;
        chk("ready_in_reset", 32'(wr_ready), 32'h0);
        tick();
        tick();
        wr_valid = '0;
        rst_n    = 1'b1;
        tick();
        chk("reset_cur", 32'(cur), 32'h10);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_ready", 32'(wr_ready), 32'h0);

        // All four writers SET A0..A3 held: grants rotate 0,1,2,3,0.
        wr_value = 32'hA3A2A1A0;
        wr_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_grant", 32'(wr_ready), 32'(4'b0001 << (i % 4)));
            tick();
            chk("rr_cur", 32'(cur), 32'(8'hA0 + 8'(i % 4)));
        end
        wr_valid = '0;
        chk("rr_flags", 32'(rd_valid), 32'h3);
        ack_all();
        chk("ack_clear", 32'(rd_valid), 32'h0);

        // Restore 0x10, then writer 2 ADD F5 wraps to 05.
        wr_value = 32'h00000010;
        wr_valid = 4'b0001;
        tick();
        wr_valid = '0;
        ack_all();
        chk("set_10", 32'(cur), 32'h10);
        wr_value = 32'h00F50000;
        wr_add   = 4'b0100;
        wr_valid = 4'b0100;
        #1;
        chk("add_grant", 32'(wr_ready), 32'h4);
        tick();
        wr_valid = '0;
        wr_add   = '0;
        chk("add_wrap", 32'(cur), 32'h05);
        chk("add_flags", 32'(rd_valid), 32'h3);
        chk("add_rd_value", 32'(rd_value), 32'h0505);
        ack_all();

        // SET to the value already stored: notifies only without CHG_ONLY.
        wr_value = 32'h00000010;
        wr_valid = 4'b0001;
        tick();
        wr_valid = '0;
        ack_all();
        chk("pre_same_flags", 32'(rd_valid), 32'h0);
        wr_valid = 4'b0001;
        tick();
        wr_valid = '0;
        chk("same_cur", 32'(cur), 32'h10);
        chk("same_no_flag", 32'(rd_valid), 32'h0);
        chk("same_nc_flag", 32'(rd_valid_nc), 32'h3);
        ack_all();
        chk("nc_cleared", 32'(rd_valid_nc), 32'h0);

        // Reader 0 stalls across three writes; reader 1 acks each.
        hs1      = 0;
        wr_value = 32'h00002100;
        wr_valid = 4'b0010;
        tick();
        wr_valid = '0;
        chk("w21_flags", 32'(rd_valid), 32'h3);
        rd_ready = 2'b10;
        tick();
        chk("r1_cleared", 32'(rd_valid), 32'h1);
        wr_value = 32'h00002200;
        wr_valid = 4'b0010;
        tick();
        chk("w22_flags", 32'(rd_valid), 32'h3);
        wr_value = 32'h00002300;
        tick();
        wr_valid = '0;
        chk("set_wins", 32'(rd_valid), 32'h3);
        tick();
        rd_ready = 2'b00;
        chk("r0_one_flag", 32'(rd_valid), 32'h1);
        chk("r0_latest", 32'(rd_value[7:0]), 32'h23);
        chk("r1_handshakes", 32'(hs1), 32'd3);
        ack_all();

        // Reset mid-burst with both flags pending.
        wr_value = 32'hA3A2A1A0;
        wr_valid = 4'b1111;
        tick();
        chk("burst_w2", 32'(cur), 32'hA2);
        tick();
        chk("burst_w3", 32'(cur), 32'hA3);
        chk("burst_flags", 32'(rd_valid), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("rst_cur", 32'(cur), 32'h10);
        chk("rst_flags", 32'(rd_valid), 32'h0);
        chk("rst_ready", 32'(wr_ready), 32'h0);
        tick();
        chk("rst_discard", 32'(cur), 32'h10);
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(wr_ready), 32'h1);
        tick();
        wr_valid = '0;
        chk("post_rst_cur", 32'(cur), 32'hA0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
